// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and helper functions for the MAC datapath
package mac_pkg;
   localparam int MAC_DATA_WIDTH = 14;
   localparam int MAC_OUT_WIDTH = 14;

   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // number of elements left after k pairwise reduction levels
   function automatic int level_count(input int n, input int k);
      return (n + (1 << k) - 1) >> k;
   endfunction

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      return (value > hi) ? hi : (value < lo) ? lo : value;
   endfunction
endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered level of pairwise signed sums
module adder_tree_level #(
   parameter int IN_COUNT = 2,
   parameter int IN_WIDTH = 14
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic [IN_COUNT*IN_WIDTH-1:0] in_data,
   output logic out_valid,
   output logic [((IN_COUNT+1)/2)*(IN_WIDTH+1)-1:0] out_data
);
   localparam int OC = (IN_COUNT + 1) / 2;
   localparam int OW = IN_WIDTH + 1;

   logic [OC*OW-1:0] sums;

   for (genvar i = 0; i < OC; i++) begin : g_pair
      logic signed [OW-1:0] a, b;
      assign a = OW'($signed(in_data[2*i*IN_WIDTH +: IN_WIDTH]));
      // an odd leftover element passes through with a zero partner
      if (2*i + 1 < IN_COUNT) begin : g_two
         assign b = OW'($signed(in_data[(2*i+1)*IN_WIDTH +: IN_WIDTH]));
      end else begin : g_one
         assign b = '0;
      end
      assign sums[i*OW +: OW] = a + b;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_data <= '0;
      end else begin
         out_valid <= in_valid;
         out_data <= sums;
      end
endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree with per-group accumulator, bias and saturation
module adder_tree_acc
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_WIDTH,
   parameter int NUM_INPUTS = 27,
   parameter int OUT_WIDTH = MAC_OUT_WIDTH,
   parameter int GROUP_BITS = 8,
   parameter int SAT_EN = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_last,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic signed [DATA_WIDTH-1:0] bias_in,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic out_valid,
   output logic out_overflow
);
   localparam int TREE_DEPTH = clog2(NUM_INPUTS);
   localparam int ACC_WIDTH = DATA_WIDTH + TREE_DEPTH + GROUP_BITS + 1;
   localparam int SUM_WIDTH = DATA_WIDTH + TREE_DEPTH;

   for (genvar k = 0; k <= TREE_DEPTH; k++) begin : g_lvl
      logic [level_count(NUM_INPUTS, k)*(DATA_WIDTH+k)-1:0] d;
      logic v;
      if (k == 0) begin : g_in
         assign d = in_data;
         assign v = in_valid;
      end else begin : g_add
         adder_tree_level #(
            .IN_COUNT(level_count(NUM_INPUTS, k - 1)),
            .IN_WIDTH(DATA_WIDTH + k - 1)
         ) u_level (
            .clk(clk),
            .rst(rst),
            .in_valid(g_lvl[k-1].v),
            .in_data(g_lvl[k-1].d),
            .out_valid(v),
            .out_data(d)
         );
      end
   end

   // last flag and bias ride alongside the tree so they meet the matching sum
   logic [DATA_WIDTH:0] side [TREE_DEPTH];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < TREE_DEPTH; i++) side[i] <= '0;
      end else begin
         side[0] <= {in_last & in_valid, bias_in};
         for (int i = 1; i < TREE_DEPTH; i++) side[i] <= side[i-1];
      end

   logic tree_valid, tree_last, first_flag;
   logic signed [SUM_WIDTH-1:0] tree_sum;
   logic signed [DATA_WIDTH-1:0] tree_bias;
   logic signed [ACC_WIDTH-1:0] acc, base, sum;
   logic signed [63:0] sum_wide, sum_sat;

   assign tree_valid = g_lvl[TREE_DEPTH].v;
   assign tree_sum = g_lvl[TREE_DEPTH].d;
   assign {tree_last, tree_bias} = side[TREE_DEPTH-1];

   always_comb begin
      base = first_flag ? ACC_WIDTH'(tree_bias) : acc;
      sum = base + ACC_WIDTH'(tree_sum);
      sum_wide = 64'(sum);
      sum_sat = sat_signed(sum_wide, OUT_WIDTH);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         first_flag <= 1'b1;
         out_data <= '0;
         out_valid <= 1'b0;
         out_overflow <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (tree_valid) begin
            if (tree_last) begin
               out_data <= (SAT_EN != 0) ? sum_sat[OUT_WIDTH-1:0] : sum[OUT_WIDTH-1:0];
               out_overflow <= sum_sat != sum_wide;
               out_valid <= 1'b1;
               acc <= '0;
               first_flag <= 1'b1;
            end else begin
               acc <= sum;
               first_flag <= 1'b0;
            end
         end
      end
endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed checks of the adder tree accumulator, saturating and wrapping builds
module tb_adder_tree_acc;
   localparam int DW = 14;
   localparam int N = 27;
   localparam int OW = 14;

   logic clk = 1'b0;
   logic rst, in_valid, in_last;
   logic [N*DW-1:0] in_data;
   logic signed [DW-1:0] bias_in;
   logic signed [OW-1:0] out_data, wrap_data;
   logic out_valid, out_overflow, wrap_valid, wrap_overflow;
   int total = 0;
   int bad = 0;
   int lat, hits;

   always #5 clk = ~clk;

   adder_tree_acc #(.SAT_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .bias_in(bias_in), .out_data(out_data), .out_valid(out_valid), .out_overflow(out_overflow)
   );

   adder_tree_acc #(.SAT_EN(0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .bias_in(bias_in), .out_data(wrap_data), .out_valid(wrap_valid), .out_overflow(wrap_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(v);
   endtask

   task automatic beat(input int bias, input logic last);
      bias_in = DW'(bias);
      in_valid = 1'b1;
      in_last = last;
      step();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   // cycles from presenting the last beat until out_valid, capped at 12
   task automatic wait_out(output int n);
      n = 1;
      while (!out_valid && n < 12) begin
         step();
         n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      bias_in = '0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ovf", out_overflow, 0);
      chk("rst_wrap_valid", wrap_valid, 0);
      @(negedge clk) rst = 1'b0;
      step();

      fill(1);
      beat(0, 1'b1);
      wait_out(lat);
      chk("ones_latency", lat, 6);
      chk("ones_data", out_data, 27);
      chk("ones_ovf", out_overflow, 0);
      step();
      chk("hold_valid", out_valid, 0);
      chk("hold_data", out_data, 27);

      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = (i < 13) ? DW'(-100) : DW'(50);
      beat(0, 1'b1);
      wait_out(lat);
      chk("mixed_latency", lat, 6);
      chk("mixed_data", out_data, -600);
      chk("mixed_ovf", out_overflow, 0);

      bias_in = '0;
      in_valid = 1'b1;
      in_last = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         fill(k);
         step();
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      step();
      chk("b2b_pre_valid", out_valid, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("b2b_valid", out_valid, 1);
         chk("b2b_data", out_data, 27 * k);
      end

      fill(100);
      beat(5, 1'b0);
      beat(77, 1'b0);
      step();
      beat(77, 1'b1);
      wait_out(lat);
      chk("group_latency", lat, 6);
      chk("group_data", out_data, 8105);
      chk("group_ovf", out_overflow, 0);
      chk("group_wrap_data", wrap_data, 8105);

      fill(8191);
      beat(0, 1'b1);
      wait_out(lat);
      chk("satpos_latency", lat, 6);
      chk("satpos_data", out_data, 8191);
      chk("satpos_ovf", out_overflow, 1);
      chk("wrap_valid", wrap_valid, 1);
      chk("wrap_data", wrap_data, 8165);
      chk("wrap_ovf", wrap_overflow, 1);

      fill(-8192);
      beat(0, 1'b1);
      wait_out(lat);
      chk("satneg_latency", lat, 6);
      chk("satneg_data", out_data, -8192);
      chk("satneg_ovf", out_overflow, 1);

      fill(100);
      beat(3, 1'b0);
      beat(0, 1'b0);
      rst = 1'b1;
      #3;
      rst = 1'b0;
      chk("midrst_data", out_data, 0);
      hits = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (out_valid) hits++;
      end
      chk("midrst_no_valid", hits, 0);
      fill(1);
      beat(0, 1'b1);
      wait_out(lat);
      chk("after_rst_latency", lat, 6);
      chk("after_rst_data", out_data, 27);
      chk("after_rst_ovf", out_overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
